// File: rtl/sync_fifo_if.sv
// Purpose : Handshake/data bundle between a same-clock producer/consumer pair
//           and sync_fifo.
// Signals : winc, wdata, rinc          - requests from the user side
//           rdata                      - read data from the FIFO
//           full, empty                - occupancy extremes
//           almost_full, almost_empty  - programmable occupancy thresholds
//           count                      - words held, 0..2**ADDR_WIDTH
//           overflow, underflow        - sticky error flags
// Modports: master = user side, slave = FIFO side.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Purpose : Single-clock FIFO with occupancy count, programmable almost-full /
//           almost-empty thresholds and sticky overflow/underflow errors.
//           Optional first-word-fall-through read mode selected by the macro
//           SYNC_FIFO_FWFT_EN (undefined: registered read, 1-cycle latency).
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous reset, active-high
//           bus  - sync_fifo_if.slave (winc/wdata/rinc in; rdata, flags,
//                  count, overflow, underflow out)
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_if.slave      bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range_err
      $error("sync_fifo: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range_err
      $error("sync_fifo: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Flags depend only on the registered count, so acceptance is decided on
  // the state seen at the edge; the pointer MSB is just a wrap bit here.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_en = bus.winc & ~w_full;
  assign w_rd_en = bus.rinc & ~w_empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + C_ONE;
      if (w_rd_en) r_rptr <= r_rptr + C_ONE;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (bus.winc && w_full)  r_overflow  <= 1'b1;
      if (bus.rinc && w_empty) r_underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is always presented; content while empty is meaningless.
  assign bus.rdata = r_mem[r_rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.rdata = r_rdata;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
